// File: rtl/edit_mem_buf_release_pkg.sv
// Shared constants and types for the edit-memory buffer release block.
// Holds the default widths for buffer pointer, port id and read count, and
// the operation tag carried down the release pipeline.
package edit_mem_buf_release_pkg;

  localparam int EM_BUF_PTR_NBITS = 6;
  localparam int PORT_ID_NBITS    = 3;
  localparam int READ_COUNT_NBITS = 4;

  // Operation travelling through S0/S1: a count initialisation or a
  // single-read decrement.
  typedef enum logic {
    OP_DEC  = 1'b0,
    OP_INIT = 1'b1
  } rc_op_e;

endpackage

// File: rtl/edit_mem_buf_release_rc_fwd.sv
// edit_mem_rc_fwd: S1 count resolution for the buffer release pipeline.
// Chooses the current count (forwarded last write or RAM read data),
// computes the new count and decides write / free-push / underflow.
// Ports:
//   s1_vld, s1_op, s1_ptr, s1_rc        op held in S1
//   ram_dout                            registered RAM read for s1_ptr
//   wr_vld_q, wr_ptr_q, wr_data_q       RAM write issued in the previous cycle
//   wr_en, new_cnt                      RAM write for this cycle (at s1_ptr)
//   push                                new count is zero: free the buffer
//   underflow                           decrement of a count that is already 0
module edit_mem_rc_fwd
  import edit_mem_buf_release_pkg::*;
#(
  parameter int BPTR_NBITS = EM_BUF_PTR_NBITS,
  parameter int RC_NBITS   = READ_COUNT_NBITS
) (
  input  logic                  s1_vld,
  input  rc_op_e                s1_op,
  input  logic [BPTR_NBITS-1:0] s1_ptr,
  input  logic [RC_NBITS-1:0]   s1_rc,
  input  logic [RC_NBITS-1:0]   ram_dout,
  input  logic                  wr_vld_q,
  input  logic [BPTR_NBITS-1:0] wr_ptr_q,
  input  logic [RC_NBITS-1:0]   wr_data_q,
  output logic                  wr_en,
  output logic [RC_NBITS-1:0]   new_cnt,
  output logic                  push,
  output logic                  underflow
);

  logic [RC_NBITS-1:0] cur;

  // The RAM read for this op was launched on the same edge that committed
  // the previous op's write, so a matching pointer takes the written value.
  assign cur = (wr_vld_q && (wr_ptr_q == s1_ptr)) ? wr_data_q : ram_dout;

  always_comb begin
    wr_en     = 1'b0;
    new_cnt   = cur;
    push      = 1'b0;
    underflow = 1'b0;
    if (s1_vld) begin
      if (s1_op == OP_INIT) begin
        wr_en   = 1'b1;
        new_cnt = s1_rc;
        push    = (s1_rc == '0);
      end else if (cur == '0) begin
        underflow = 1'b1;   // count left untouched, nothing freed
      end else begin
        wr_en   = 1'b1;
        new_cnt = cur - RC_NBITS'(1);
        push    = (cur == RC_NBITS'(1));
      end
    end
  end

endmodule

// File: rtl/edit_mem_buf_release.sv
// edit_mem_buf_release: per-buffer read reference counts. The linked-list
// stage initialises a buffer's count, egress decrements it once per finished
// read, and a buffer reaching zero is queued for return to the free list.
// Optional: EM_BUF_RELEASE_STATS_EN adds stat_freed / stat_underflow /
// stat_init_zero counters.
// Ports:
//   clk, rst (async, active-high)
//   read_count_valid/_port_id/_buf_ptr, read_count   count init, always taken
//   rd_done_valid/_buf_ptr, rd_done_ready            one read finished
//   free_buf_valid/_ptr, free_buf_ready              FWFT free-pointer queue
//   err_underflow                                    decrement of a zero count
module edit_mem_buf_release
  import edit_mem_buf_release_pkg::*;
#(
  parameter int BPTR_NBITS = EM_BUF_PTR_NBITS,
  parameter int ID_NBITS   = PORT_ID_NBITS,
  parameter int RC_NBITS   = READ_COUNT_NBITS,
  parameter int FREE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_count_valid,
  input  logic [ID_NBITS-1:0]   read_count_port_id,
  input  logic [BPTR_NBITS-1:0] read_count_buf_ptr,
  input  logic [RC_NBITS-1:0]   read_count,
  input  logic                  rd_done_valid,
  input  logic [BPTR_NBITS-1:0] rd_done_buf_ptr,
  output logic                  rd_done_ready,
  output logic                  free_buf_valid,
  output logic [BPTR_NBITS-1:0] free_buf_ptr,
  input  logic                  free_buf_ready,
`ifdef EM_BUF_RELEASE_STATS_EN
  output logic [31:0]           stat_freed,
  output logic [15:0]           stat_underflow,
  output logic [15:0]           stat_init_zero,
`endif
  output logic                  err_underflow
);

  localparam int AW = $clog2(FREE_DEPTH);

  // Port id only feeds external statistics.
  logic unused_port_id;
  assign unused_port_id = ^read_count_port_id;

  logic                  run_q;
  logic                  accept;
  rc_op_e                s0_op;
  logic [BPTR_NBITS-1:0] s0_ptr;
  logic                  s1_vld;
  rc_op_e                s1_op;
  logic [BPTR_NBITS-1:0] s1_ptr;
  logic [RC_NBITS-1:0]   s1_rc;
  logic [RC_NBITS-1:0]   ram_dout;
  logic [RC_NBITS-1:0]   cnt_ram [2**BPTR_NBITS];
  logic                  wr_en, fwd_push;
  logic [RC_NBITS-1:0]   new_cnt;
  logic                  wr_vld_q;
  logic [BPTR_NBITS-1:0] wr_ptr_q;
  logic [RC_NBITS-1:0]   wr_data_q;
  logic [BPTR_NBITS-1:0] fq_mem [FREE_DEPTH];
  logic [AW:0]           fq_wp, fq_rp, fq_cnt;
  logic                  fq_push, fq_pop, fq_full;
  logic [AW+1:0]         occ;

  // S0: init wins; rd_done only when no init and a free slot is reserved
  // for every op that could still push.
  assign fq_cnt  = fq_wp - fq_rp;
  assign fq_full = (fq_cnt == (AW+1)'(FREE_DEPTH));
  assign occ     = (AW+2)'(fq_cnt) + (AW+2)'(s1_vld);
  assign rd_done_ready = run_q & ~read_count_valid & (occ < (AW+2)'(FREE_DEPTH));
  assign accept  = read_count_valid | (rd_done_valid & rd_done_ready);
  assign s0_op   = read_count_valid ? OP_INIT : OP_DEC;
  assign s0_ptr  = read_count_valid ? read_count_buf_ptr : rd_done_buf_ptr;

  // Count RAM: registered read, contents not reset.
  always_ff @(posedge clk) begin
    if (wr_en) cnt_ram[s1_ptr] <= new_cnt;
    ram_dout <= cnt_ram[s0_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= 1'b0;
      s1_vld    <= 1'b0;
      s1_op     <= OP_DEC;
      s1_ptr    <= '0;
      s1_rc     <= '0;
      wr_vld_q  <= 1'b0;
      wr_ptr_q  <= '0;
      wr_data_q <= '0;
    end else begin
      run_q     <= 1'b1;
      s1_vld    <= accept;
      s1_op     <= s0_op;
      s1_ptr    <= s0_ptr;
      s1_rc     <= read_count;
      wr_vld_q  <= wr_en;
      wr_ptr_q  <= s1_ptr;
      wr_data_q <= new_cnt;
    end
  end

  edit_mem_rc_fwd #(
    .BPTR_NBITS (BPTR_NBITS),
    .RC_NBITS   (RC_NBITS)
  ) u_fwd (
    .s1_vld    (s1_vld),
    .s1_op     (s1_op),
    .s1_ptr    (s1_ptr),
    .s1_rc     (s1_rc),
    .ram_dout  (ram_dout),
    .wr_vld_q  (wr_vld_q),
    .wr_ptr_q  (wr_ptr_q),
    .wr_data_q (wr_data_q),
    .wr_en     (wr_en),
    .new_cnt   (new_cnt),
    .push      (fwd_push),
    .underflow (err_underflow)
  );

  // Free-pointer FIFO, first-word fall-through. The full guard only matters
  // for zero-count inits, which bypass the ready reservation.
  assign fq_push        = fwd_push & ~fq_full;
  assign free_buf_valid = (fq_cnt != '0);
  assign fq_pop         = free_buf_valid & free_buf_ready;
  assign free_buf_ptr   = fq_mem[fq_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (fq_push) fq_mem[fq_wp[AW-1:0]] <= s1_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq_wp <= '0;
      fq_rp <= '0;
    end else begin
      if (fq_push) fq_wp <= fq_wp + 1'b1;
      if (fq_pop)  fq_rp <= fq_rp + 1'b1;
    end
  end

`ifdef EM_BUF_RELEASE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_freed     <= '0;
      stat_underflow <= '0;
      stat_init_zero <= '0;
    end else begin
      if (fq_push) stat_freed <= stat_freed + 32'd1;
      if (err_underflow && stat_underflow != 16'hffff)
        stat_underflow <= stat_underflow + 16'd1;
      if (s1_vld && s1_op == OP_INIT && s1_rc == '0 && stat_init_zero != 16'hffff)
        stat_init_zero <= stat_init_zero + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_edit_mem_buf_release.sv
// Bench for edit_mem_buf_release: directed scenarios followed by random
// traffic, every cycle compared with a sequential reference-count model.
module tb_edit_mem_buf_release;
  localparam int BP = 6, ID = 3, RC = 4, FD = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          read_count_valid = 1'b0;
  logic [ID-1:0] read_count_port_id = '0;
  logic [BP-1:0] read_count_buf_ptr = '0;
  logic [RC-1:0] read_count = '0;
  logic          rd_done_valid = 1'b0;
  logic [BP-1:0] rd_done_buf_ptr = '0;
  logic          rd_done_ready, free_buf_valid, err_underflow;
  logic [BP-1:0] free_buf_ptr;
  logic          free_buf_ready = 1'b1;
`ifdef EM_BUF_RELEASE_STATS_EN
  logic [31:0]   stat_freed;
  logic [15:0]   stat_underflow, stat_init_zero;
`endif

  edit_mem_buf_release #(.BPTR_NBITS(BP), .ID_NBITS(ID), .RC_NBITS(RC), .FREE_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .read_count_valid(read_count_valid), .read_count_port_id(read_count_port_id),
    .read_count_buf_ptr(read_count_buf_ptr), .read_count(read_count),
    .rd_done_valid(rd_done_valid), .rd_done_buf_ptr(rd_done_buf_ptr),
    .rd_done_ready(rd_done_ready),
    .free_buf_valid(free_buf_valid), .free_buf_ptr(free_buf_ptr),
    .free_buf_ready(free_buf_ready),
`ifdef EM_BUF_RELEASE_STATS_EN
    .stat_freed(stat_freed), .stat_underflow(stat_underflow), .stat_init_zero(stat_init_zero),
`endif
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int compared = 0, mismatched = 0;

  // Reference model: counts change in op order; ops accepted last cycle sit
  // in a one-deep "in flight" slot and join the expected free queue a cycle
  // later.
  int  cnt_m [64];
  bit  known [64];
  int  pop_cnt [64];
  int  q [$];
  int  popped_seq [$];
  bit  fl_v, fl_push, fl_uf;
  int  fl_ptr;
  int  total_push = 0;
  bit  dec_acc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, update the model at the rising
  // edge, return 1 time unit later so callers can change inputs.
  task automatic cycle();
    bit mrdy, popped, init, dec;
    @(negedge clk);
    mrdy = !read_count_valid && ((q.size() + int'(fl_v)) < FD);
    chk("rd_done_ready", {31'b0, rd_done_ready}, {31'b0, mrdy});
    chk("err_underflow", {31'b0, err_underflow}, {31'b0, fl_v && fl_uf});
    chk("free_buf_valid", {31'b0, free_buf_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) chk("free_buf_ptr", {26'b0, free_buf_ptr}, q[0]);
    popped = (q.size() != 0) && free_buf_ready;
    init   = read_count_valid;
    dec    = !read_count_valid && rd_done_valid && mrdy;
    dec_acc = dec;
    @(posedge clk);
    if (popped) begin
      pop_cnt[q[0]]++;
      popped_seq.push_back(q[0]);
      void'(q.pop_front());
    end
    if (fl_v && fl_push) begin
      q.push_back(fl_ptr);
      total_push++;
    end
    fl_v = init || dec; fl_push = 0; fl_uf = 0;
    if (init) begin
      fl_ptr = int'(read_count_buf_ptr);
      cnt_m[fl_ptr] = int'(read_count);
      known[fl_ptr] = 1;
      fl_push = (read_count == 0);
    end else if (dec) begin
      fl_ptr = int'(rd_done_buf_ptr);
      if (cnt_m[fl_ptr] == 0) fl_uf = 1;
      else begin
        cnt_m[fl_ptr]--;
        fl_push = (cnt_m[fl_ptr] == 0);
      end
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_init(int p, int rc);
    read_count_valid = 1; read_count_buf_ptr = BP'(p); read_count = RC'(rc);
    read_count_port_id = ID'($urandom_range(0, 7));
    cycle();
    read_count_valid = 0;
  endtask

  // Holds a decrement until the DUT accepts it, within a cycle budget.
  task automatic do_dec(int p);
    bit done = 0;
    rd_done_valid = 1; rd_done_buf_ptr = BP'(p);
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      done = dec_acc;
    end
    chk("dec_accepted_in_budget", {31'b0, done}, 32'd1);
    rd_done_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin cnt_m[i] = 0; known[i] = 0; pop_cnt[i] = 0; end
    fl_v = 0; fl_push = 0; fl_uf = 0; fl_ptr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_done_ready", {31'b0, rd_done_ready}, 32'd0);
    chk("rst_free_buf_valid", {31'b0, free_buf_valid}, 32'd0);
    chk("rst_err_underflow", {31'b0, err_underflow}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // 1: gapped decs on 5
    do_init(5, 2); idle(2);
    do_dec(5); idle(2);
    do_dec(5);
    chk("t1_no_free_yet", {31'b0, free_buf_valid}, 32'd0);
    idle(1);
    chk("t1_free_visible", {31'b0, free_buf_valid}, 32'd1);
    chk("t1_free_ptr", {26'b0, free_buf_ptr}, 32'd5);
    idle(3);
    chk("t1_one_free", pop_cnt[5], 32'd1);

    // 2: back-to-back decs on 9 exercise forwarding
    do_init(9, 3);
    rd_done_valid = 1; rd_done_buf_ptr = 9;
    begin
      int acc = 0;
      for (int i = 0; i < 20 && acc < 3; i++) begin cycle(); if (dec_acc) acc++; end
      chk("t2_three_accepted", acc, 32'd3);
    end
    rd_done_valid = 0;
    idle(4);
    chk("t2_one_free", pop_cnt[9], 32'd1);

    // 3: zero-count init frees immediately
    do_init(7, 0); idle(3);
    chk("t3_one_free", pop_cnt[7], 32'd1);

    // 4: underflow on 3 (count made zero first)
    do_init(3, 0); idle(3);
    do_dec(3);
    chk("t4_underflow_pulse", {31'b0, err_underflow}, 32'd1);
    idle(2);
    chk("t4_no_extra_free", pop_cnt[3], 32'd1);
    chk("t4_count_stays", cnt_m[3], 32'd0);

    // 5: backpressure from a full free queue
    free_buf_ready = 0;
    for (int i = 0; i < 5; i++) do_init(10 + i, 1);
    for (int i = 0; i < 4; i++) do_dec(10 + i);
    rd_done_valid = 1; rd_done_buf_ptr = 14;
    idle(2);
    chk("t5_ready_blocked", {31'b0, rd_done_ready}, 32'd0);
    popped_seq.delete();
    free_buf_ready = 1;
    begin
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin cycle(); done = dec_acc; end
      chk("t5_ready_recovered", {31'b0, done}, 32'd1);
    end
    rd_done_valid = 0;
    idle(6);
    chk("t5_pop_count", popped_seq.size(), 32'd5);
    for (int i = 0; i < 5 && i < popped_seq.size(); i++)
      chk("t5_pop_order", popped_seq[i], 10 + i);

    // 6: init and rd_done together: init wins, dec accepted third cycle
    do_init(20, 2);
    rd_done_valid = 1; rd_done_buf_ptr = 20;
    read_count_valid = 1; read_count_buf_ptr = 21; read_count = 1;
    cycle();
    chk("t6_blocked_c1", {31'b0, dec_acc}, 32'd0);
    read_count_buf_ptr = 22;
    cycle();
    chk("t6_blocked_c2", {31'b0, dec_acc}, 32'd0);
    read_count_valid = 0;
    cycle();
    chk("t6_dec_c3", {31'b0, dec_acc}, 32'd1);
    rd_done_valid = 0;
    idle(2);
    chk("t6_count_after", cnt_m[20], 32'd1);
    do_dec(20); idle(3);
    chk("t6_freed", pop_cnt[20], 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      free_buf_ready = ($urandom_range(0, 9) < 7);
      if (!rd_done_valid || dec_acc) begin
        rd_done_valid = 0;
        if ($urandom_range(0, 1) == 1) begin
          int p = $urandom_range(0, 63);
          if (known[p]) begin rd_done_valid = 1; rd_done_buf_ptr = BP'(p); end
        end
      end
      read_count_valid = 0;
      if ($urandom_range(0, 9) < 3) begin
        int rc = $urandom_range(0, 3);
        if (rc == 0 && (q.size() + int'(fl_v)) > 1) rc = 1;
        read_count_valid = 1;
        read_count_buf_ptr = BP'($urandom_range(0, 63));
        read_count = RC'(rc);
        read_count_port_id = ID'($urandom_range(0, 7));
      end
      cycle();
    end
    read_count_valid = 0; rd_done_valid = 0; free_buf_ready = 1;
    idle(8);
    chk("drain_empty", {31'b0, free_buf_valid}, 32'd0);
`ifdef EM_BUF_RELEASE_STATS_EN
    chk("stat_freed", stat_freed, total_push);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
